// File: rtl/tff_toggle_cell.sv
// Single-bit T flip-flop with asynchronous active-high reset.
module tff_toggle_cell #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/tff_toggle.sv
// WIDTH independent T flip-flops; q_bar is an inverter on the q register.
module tff_toggle #(
   parameter int unsigned           WIDTH   = 1,
   parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar
);

   if (WIDTH < 1) begin : g_width_check
      $error("tff_toggle: WIDTH must be at least 1");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_toggle_cell #(
         .RST_VAL (RST_VAL[i])
      ) u_cell (
         .clk (clk),
         .rst (rst),
         .t   (t[i]),
         .q   (q[i])
      );
   end

   // Complement taken straight from the register so q and q_bar cannot diverge.
   assign q_bar = ~q;

   always_comb begin
      assert (q_bar == ~q);
   end

endmodule

// File: tb/tb_tff_toggle.sv
// Directed self-checking bench for tff_toggle (default and 4-bit configurations).
module tb_tff_toggle;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       t   = 1'b0;
   logic       q, q_bar;
   logic [3:0] t4  = 4'b0000;
   logic [3:0] q4, q4_bar;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tff_toggle u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .t     (t),
      .q     (q),
      .q_bar (q_bar)
   );

   tff_toggle #(
      .WIDTH   (4),
      .RST_VAL (4'b1010)
   ) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .t     (t4),
      .q     (q4),
      .q_bar (q4_bar)
   );

   task automatic test_reset();
      t = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (q !== 1'b0 || q_bar !== 1'b1) begin
         errors++;
         $display("FAIL reset_init q=%b q_bar=%b expected q=0 q_bar=1", q, q_bar);
      end
      checks++;
      if (q4 !== 4'b1010 || q4_bar !== 4'b0101) begin
         errors++;
         $display("FAIL reset_init4 q=%b q_bar=%b expected q=1010 q_bar=0101", q4, q4_bar);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (q !== 1'b1 || q_bar !== 1'b0) begin
         errors++;
         $display("FAIL first_edge q=%b q_bar=%b expected q=1 q_bar=0", q, q_bar);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (q !== 1'b0 || q_bar !== 1'b1) begin
         errors++;
         $display("FAIL async_reset q=%b q_bar=%b expected q=0 q_bar=1", q, q_bar);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (q !== 1'b0 || q_bar !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold_edge%0d q=%b q_bar=%b expected q=0 q_bar=1", i, q, q_bar);
         end
      end
      t = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_hold();
      t = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (q !== 1'b0 || q_bar !== 1'b1) begin
            errors++;
            $display("FAIL hold_edge%0d q=%b q_bar=%b expected q=0 q_bar=1", i, q, q_bar);
         end
      end
   endtask

   task automatic test_toggle_seq();
      logic tv [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic exq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      t = tv[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (q !== exq[i] || q_bar !== ~exq[i]) begin
            errors++;
            $display("FAIL toggle_seq%0d q=%b q_bar=%b expected q=%b q_bar=%b",
                     i, q, q_bar, exq[i], ~exq[i]);
         end
         if (i < 3) t = tv[i+1];
      end
   endtask

   task automatic test_div2();
      logic exp_q = 1'b1;
      t = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         exp_q = ~exp_q;
         checks++;
         if (q !== exp_q || q_bar !== ~exp_q) begin
            errors++;
            $display("FAIL div2_edge%0d q=%b q_bar=%b expected q=%b q_bar=%b",
                     i, q, q_bar, exp_q, ~exp_q);
         end
      end
      t = 1'b0;
   endtask

   task automatic test_width();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (q4 !== 4'b1010 || q4_bar !== 4'b0101) begin
         errors++;
         $display("FAIL width_reset q=%b q_bar=%b expected q=1010 q_bar=0101", q4, q4_bar);
      end
      @(negedge clk);
      rst = 1'b0;
      t4 = 4'b0011;
      @(posedge clk);
      #1;
      checks++;
      if (q4 !== 4'b1001 || q4_bar !== 4'b0110) begin
         errors++;
         $display("FAIL width_t0011 q=%b q_bar=%b expected q=1001 q_bar=0110", q4, q4_bar);
      end
      t4 = 4'b1100;
      @(posedge clk);
      #1;
      checks++;
      if (q4 !== 4'b0101 || q4_bar !== 4'b1010) begin
         errors++;
         $display("FAIL width_t1100 q=%b q_bar=%b expected q=0101 q_bar=1010", q4, q4_bar);
      end
      t4 = 4'b0000;
      @(posedge clk);
      #1;
      checks++;
      if (q4 !== 4'b0101) begin
         errors++;
         $display("FAIL width_hold q=%b expected q=0101", q4);
      end
   endtask

   task automatic test_reset_mid();
      // dut1 is at 0 here (reset in test_width, t held 0 since)
      t = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (q !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup q=%b expected q=1", q);
      end
      @(negedge clk);
      #4 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if (q !== 1'b0 || q_bar !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset q=%b q_bar=%b expected q=0 q_bar=1", q, q_bar);
      end
      checks++;
      if (q4 !== 4'b1010) begin
         errors++;
         $display("FAIL mid_reset4 q=%b expected q=1010", q4);
      end
      @(posedge clk);
      #1;
      checks++;
      if (q !== 1'b1 || q_bar !== 1'b0) begin
         errors++;
         $display("FAIL mid_after q=%b q_bar=%b expected q=1 q_bar=0", q, q_bar);
      end
      t = 1'b0;
   endtask

   initial begin
      test_reset();
      test_hold();
      test_toggle_seq();
      test_div2();
      test_width();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
